// File: rtl/reset_sequencer.sv
// reset_sequencer: staged board reset from button + filtered PLL lock; ports clk/rst, btn_rst_n, pll_locked -> stage_rst_n, sys_ready, state_o, lock_loss_cnt
module reset_sequencer #(
  parameter int STRETCH_CYCLES = 1000,
  parameter int NUM_STAGES     = 2,
  parameter int STAGE_GAP      = 16,
  parameter int LOCK_FILTER    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_rst_n,
  input  logic                  pll_locked,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  sys_ready,
  output logic [2:0]            state_o,
  output logic [3:0]            lock_loss_cnt
);
  localparam int SW = $clog2(STRETCH_CYCLES + 1);
  localparam int GW = $clog2(STAGE_GAP + 1);
  localparam int FW = $clog2(LOCK_FILTER + 1);
  localparam logic [SW-1:0] STR_LAST = SW'(STRETCH_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(STAGE_GAP - 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(LOCK_FILTER);
  typedef enum logic [2:0] {HOLD = 3'd0, WAIT_LOCK = 3'd1, STRETCH = 3'd2, STAGE = 3'd3, RUN = 3'd4} state_t;
  state_t                state_q, state_d;
  logic                  sync1_q, locked_s_q;
  logic [FW-1:0]         filt_cnt_q, filt_cnt_d;
  logic [SW-1:0]         str_cnt_q, str_cnt_d;
  logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  ready_q, ready_d;
  logic [3:0]            loss_q, loss_d;
  logic                  lock_ok;
  assign lock_ok = filt_cnt_q == FILT_MAX;
  always_comb begin
    filt_cnt_d = !locked_s_q ? '0 : lock_ok ? filt_cnt_q : filt_cnt_q + FW'(1);
    state_d    = state_q;
    str_cnt_d  = str_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    stage_d    = stage_q;
    ready_d    = ready_q;
    loss_d     = loss_q;
    if (!btn_rst_n && state_q != HOLD) begin
      state_d   = HOLD;
      str_cnt_d = '0;
      gap_cnt_d = '0;
      stage_d   = '0;
      ready_d   = 1'b0;
    end else if (!locked_s_q && (state_q == STRETCH || state_q == STAGE || state_q == RUN)) begin
      state_d   = WAIT_LOCK;
      str_cnt_d = '0;
      gap_cnt_d = '0;
      stage_d   = '0;
      ready_d   = 1'b0;
      loss_d    = &loss_q ? loss_q : loss_q + 4'd1;
    end else begin
      case (state_q)
        HOLD: state_d = btn_rst_n ? WAIT_LOCK : HOLD;
        WAIT_LOCK: begin
          state_d   = lock_ok ? STRETCH : WAIT_LOCK;
          str_cnt_d = '0;
        end
        STRETCH: begin
          state_d   = str_cnt_q == STR_LAST ? STAGE : STRETCH;
          str_cnt_d = str_cnt_q == STR_LAST ? '0 : str_cnt_q + SW'(1);
          stage_d   = str_cnt_q == STR_LAST ? NUM_STAGES'(1) : '0;
          gap_cnt_d = '0;
        end
        STAGE: begin
          // Each gap expiry either releases the next bit (shift in a 1) or, once all are out, enters RUN.
          gap_cnt_d = gap_cnt_q == GAP_LAST ? '0 : gap_cnt_q + GW'(1);
          if (gap_cnt_q == GAP_LAST) begin
            state_d = &stage_q ? RUN : STAGE;
            ready_d = &stage_q;
            stage_d = (stage_q << 1) | NUM_STAGES'(1);
          end
        end
        RUN: begin
          stage_d = '1;
          ready_d = 1'b1;
        end
        default: state_d = HOLD;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HOLD;
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
      filt_cnt_q <= '0;
      str_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      stage_q    <= '0;
      ready_q    <= 1'b0;
      loss_q     <= '0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= pll_locked;
      locked_s_q <= sync1_q;
      filt_cnt_q <= filt_cnt_d;
      str_cnt_q  <= str_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      stage_q    <= stage_d;
      ready_q    <= ready_d;
      loss_q     <= loss_d;
    end
  end
  assign stage_rst_n   = stage_q;
  assign sys_ready     = ready_q;
  assign state_o       = state_q;
  assign lock_loss_cnt = loss_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed self-checking bench for reset_sequencer
module tb_reset_sequencer;
  logic       clk, rst, btn_rst_n, pll_locked;
  logic [1:0] stage_rst_n;
  logic       sys_ready;
  logic [2:0] state_o;
  logic [3:0] lock_loss_cnt;
  int         checks = 0;
  int         errors = 0;
  int         exp_loss;
  reset_sequencer #(.STRETCH_CYCLES(10), .NUM_STAGES(2), .STAGE_GAP(4), .LOCK_FILTER(3)) dut (
    .clk(clk), .rst(rst), .btn_rst_n(btn_rst_n), .pll_locked(pll_locked),
    .stage_rst_n(stage_rst_n), .sys_ready(sys_ready), .state_o(state_o), .lock_loss_cnt(lock_loss_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_state(input logic [2:0] s, input int lim, input string tag);
    int n = 0;
    while (state_o !== s && n < lim) begin
      cyc(1);
      n++;
    end
    chk(tag, 32'(state_o), 32'(s));
  endtask
  task automatic run_seq(input string tag);
    cyc(9);
    chk({tag, "_str_state"}, 32'(state_o), 2);
    chk({tag, "_str_stage"}, 32'(stage_rst_n), 0);
    cyc(1);
    chk({tag, "_s0_state"}, 32'(state_o), 3);
    chk({tag, "_s0_stage"}, 32'(stage_rst_n), 1);
    cyc(3);
    chk({tag, "_s0_hold"}, 32'(stage_rst_n), 1);
    cyc(1);
    chk({tag, "_s1_stage"}, 32'(stage_rst_n), 3);
    cyc(3);
    chk({tag, "_pre_ready"}, 32'(sys_ready), 0);
    cyc(1);
    chk({tag, "_ready"}, 32'(sys_ready), 1);
    chk({tag, "_run"}, 32'(state_o), 4);
  endtask
  initial begin
    rst = 1'b1;
    btn_rst_n = 1'b1;
    pll_locked = 1'b1;
    cyc(5);
    chk("rst_state", 32'(state_o), 0);
    chk("rst_stage", 32'(stage_rst_n), 0);
    chk("rst_ready", 32'(sys_ready), 0);
    chk("rst_loss", 32'(lock_loss_cnt), 0);
    rst = 1'b0;
    cyc(1);
    chk("nom_wait", 32'(state_o), 1);
    cyc(4);
    chk("nom_wait_filt", 32'(state_o), 1);
    cyc(1);
    chk("nom_stretch", 32'(state_o), 2);
    run_seq("nom");
    chk("nom_loss", 32'(lock_loss_cnt), 0);
    pll_locked = 1'b0;
    cyc(1);
    chk("ll_e1", 32'(state_o), 4);
    pll_locked = 1'b1;
    cyc(1);
    chk("ll_e2", 32'(stage_rst_n), 3);
    cyc(1);
    chk("ll_state", 32'(state_o), 1);
    chk("ll_stage", 32'(stage_rst_n), 0);
    chk("ll_ready", 32'(sys_ready), 0);
    chk("ll_loss", 32'(lock_loss_cnt), 1);
    wait_state(3'd2, 40, "ll_relock");
    run_seq("ll");
    pll_locked = 1'b0;
    cyc(3);
    chk("flt_wait", 32'(state_o), 1);
    chk("flt_loss", 32'(lock_loss_cnt), 2);
    cyc(3);
    pll_locked = 1'b1;
    cyc(2);
    pll_locked = 1'b0;
    cyc(1);
    chk("flt_pulse", 32'(state_o), 1);
    pll_locked = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("flt_hold", 32'(state_o), 1);
    end
    cyc(1);
    chk("flt_enter", 32'(state_o), 2);
    cyc(10);
    chk("btn_s0_state", 32'(state_o), 3);
    chk("btn_s0_stage", 32'(stage_rst_n), 1);
    cyc(1);
    btn_rst_n = 1'b0;
    cyc(1);
    chk("btn_state", 32'(state_o), 0);
    chk("btn_stage", 32'(stage_rst_n), 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("btn_held", 32'(stage_rst_n), 0);
    end
    btn_rst_n = 1'b1;
    cyc(1);
    chk("btn_rel_wait", 32'(state_o), 1);
    cyc(1);
    chk("btn_rel_str", 32'(state_o), 2);
    run_seq("btn");
    chk("btn_loss", 32'(lock_loss_cnt), 2);
    pll_locked = 1'b0;
    cyc(2);
    btn_rst_n = 1'b0;
    cyc(1);
    chk("sim_state", 32'(state_o), 0);
    chk("sim_stage", 32'(stage_rst_n), 0);
    chk("sim_ready", 32'(sys_ready), 0);
    chk("sim_loss", 32'(lock_loss_cnt), 2);
    cyc(2);
    chk("sim_loss_hold", 32'(lock_loss_cnt), 2);
    pll_locked = 1'b1;
    btn_rst_n = 1'b1;
    wait_state(3'd2, 40, "sim_relock");
    run_seq("sim");
    pll_locked = 1'b0;
    cyc(3);
    chk("l3_state", 32'(state_o), 1);
    chk("l3_loss", 32'(lock_loss_cnt), 3);
    pll_locked = 1'b1;
    wait_state(3'd2, 40, "l3_stretch");
    chk("l3_loss_str", 32'(lock_loss_cnt), 3);
    rst = 1'b1;
    cyc(1);
    chk("mid_rst_state", 32'(state_o), 0);
    chk("mid_rst_stage", 32'(stage_rst_n), 0);
    chk("mid_rst_ready", 32'(sys_ready), 0);
    chk("mid_rst_loss", 32'(lock_loss_cnt), 0);
    rst = 1'b0;
    wait_state(3'd4, 60, "post_rst_run");
    exp_loss = 0;
    for (int i = 0; i < 20; i++) begin
      pll_locked = 1'b0;
      cyc(3);
      exp_loss = exp_loss < 15 ? exp_loss + 1 : 15;
      chk("sat_loss", 32'(lock_loss_cnt), 32'(exp_loss));
      pll_locked = 1'b1;
      wait_state(3'd4, 60, "sat_run");
    end
    chk("sat_final", 32'(lock_loss_cnt), 15);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Generates the staged board reset for the DE1-SoC top level from the debounced KEY[3] reset button and the PLL locked flag.
- Sits downstream of the key debouncer and the PLL, and upstream of the soc_system reset inputs.
- Filters the PLL lock and stretches reset after lock.
- Releases NUM_STAGES reset domains in order, with a fixed gap between releases.
- Re-asserts all resets on a button press or a lock loss, and counts lock-loss events for LED display.

Parameters:
- STRETCH_CYCLES, 1000: cycles reset is held after a filtered lock is seen; must be >= 1.
- NUM_STAGES, 2: number of reset domains; range 1..8.
- STAGE_GAP, 16: cycles between successive stage releases, and from the last release to sys_ready; must be >= 1.
- LOCK_FILTER, 8: consecutive synchronized-high cycles of pll_locked required before lock is trusted; must be >= 1.

Ports:
- clk, input, 1: 50 MHz oscillator clock; the only clock.
- rst, input, 1: synchronous, active-high global reset.
- btn_rst_n, input, 1: debounced reset button; 0 = pressed; already synchronous to clk.
- pll_locked, input, 1: PLL locked flag; asynchronous to clk.
- stage_rst_n, output, NUM_STAGES: active-low domain resets; bit 0 is released first.
- sys_ready, output, 1: high when all stages are released and the block is in RUN.
- state_o, output, 3: current state encoding (HOLD=0, WAIT_LOCK=1, STRETCH=2, STAGE=3, RUN=4).
- lock_loss_cnt, output, 4: saturating count of lock-loss events.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All outputs are registered.
- Reset values (rst=1): stage_rst_n=0 (all bits), sys_ready=0, state_o=HOLD, lock_loss_cnt=0, all internal counters 0, sync flops 0.
- Lock synchronizer: pll_locked passes through a 2-flop synchronizer to give locked_s.
- Lock filter:
  - filt_cnt increments each cycle locked_s=1 and saturates at LOCK_FILTER.
  - filt_cnt clears to 0 in any cycle locked_s=0.
  - lock_ok = (filt_cnt == LOCK_FILTER).
- HOLD: all stage_rst_n=0. Go to WAIT_LOCK when btn_rst_n=1.
- WAIT_LOCK: all stage_rst_n=0. Go to STRETCH on the edge where lock_ok=1; the stretch counter loads 0.
- STRETCH:
  - The counter counts 0..STRETCH_CYCLES-1, so the block spends exactly STRETCH_CYCLES cycles here.
  - On the exit edge, state becomes STAGE and stage_rst_n[0] goes to 1 on that same edge.
- STAGE:
  - A gap counter runs; stage_rst_n[k] goes to 1 exactly STAGE_GAP cycles after stage_rst_n[k-1].
  - STAGE_GAP cycles after the last stage is released, go to RUN with sys_ready=1.
  - Released bits stay 1 while in STAGE or RUN.
- RUN: hold all stage_rst_n=1 and sys_ready=1.
- Button abort:
  - Applies in any state other than HOLD when btn_rst_n=0.
  - Next edge: state=HOLD, all stage_rst_n=0, sys_ready=0, stretch and gap counters cleared.
- Lock-loss abort:
  - Applies in STRETCH, STAGE or RUN when locked_s=0.
  - Next edge: state=WAIT_LOCK, all stage_rst_n=0, sys_ready=0, counters cleared.
  - lock_loss_cnt increments, saturating at 15.
- Simultaneous button press and lock loss: the button wins (HOLD) and lock_loss_cnt does not increment.
- A lock glitch in WAIT_LOCK only resets filt_cnt; it is not counted.
- Latency: a pll_locked fall reaches stage_rst_n after at most 3 clk edges (2 sync flops + 1 output register). A btn_rst_n fall reaches stage_rst_n after 1 edge.
- lock_loss_cnt is cleared only by rst, never by the button.
- With NUM_STAGES=1, STAGE releases bit 0 on entry and enters RUN after STAGE_GAP cycles.

Test Plan:
Bench parameters for all scenarios: STRETCH_CYCLES=10, STAGE_GAP=4, LOCK_FILTER=3, NUM_STAGES=2.
- Nominal power-up:
  - Stimulus: rst for 5 cycles, btn_rst_n=1, pll_locked=1 throughout.
  - Required: state_o goes 0→1→2.
  - Required: stage_rst_n goes 2'b00→2'b01 exactly 10 cycles after STRETCH entry, then 2'b11 four cycles later.
  - Required: sys_ready=1 and state_o=4 four cycles after that; lock_loss_cnt=0.
- Lock filter:
  - Stimulus: in WAIT_LOCK, pll_locked pulses high for 2 cycles, low, then stays high.
  - Required: no STRETCH entry on the pulse; STRETCH is entered only once locked_s has been high for 3 consecutive cycles.
- Lock loss in RUN:
  - Stimulus: drop pll_locked for 1 cycle.
  - Required: within 3 edges stage_rst_n=2'b00, sys_ready=0, state_o=1, lock_loss_cnt=1.
  - Required: after relock, the full sequence repeats.
- Button abort mid-STAGE:
  - Stimulus: btn_rst_n=0 one cycle after stage_rst_n=2'b01.
  - Required: next edge stage_rst_n=2'b00, state_o=0; stage 1 is never released.
  - Required: releasing the button restarts from WAIT_LOCK.
- Simultaneous events and saturation:
  - Stimulus: drop btn_rst_n and pll_locked together in RUN.
  - Required: state_o=0 and lock_loss_cnt unchanged.
  - Stimulus: 20 separate lock losses in RUN.
  - Required: lock_loss_cnt saturates at 15.
- Reset mid-operation:
  - Stimulus: assert rst during STRETCH with lock_loss_cnt=3.
  - Required: next edge all outputs return to reset values and lock_loss_cnt=0.
